// File: rtl/fetch_sequencer.sv
// Fetch/sequencing unit: owns the PC and run state (IDLE/RUN/MEMWAIT/DONE) and gates commits via ExecEn.
// Optional cycle/instruction performance counters are built when PERF_CNT_EN is defined.
module fetch_sequencer #(
  parameter int         PC_W       = 10,
  parameter int         MEM_LAT    = 2,
  parameter logic [8:0] HALT_INSTR = 9'h1FF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      Instruction,
  input  logic            BranchEn,
  input  logic            Taken,
  input  logic [PC_W-1:0] BranchTarget,
  input  logic            MemAccess,
  output logic [PC_W-1:0] PC,
  output logic            ExecEn,
  output logic            Busy,
  output logic            Done
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]     CycleCount,
  output logic [15:0]     InstrCount
`endif
);

  localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, MEMWAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              exec_en;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    exec_en = 1'b0;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (Start) state_d = RUN;
      end
      RUN: begin
        // Halt outranks memory stalls, which outrank branches.
        if (Instruction == HALT_INSTR) begin
          state_d = DONE;
        end else if (MemAccess && (MEM_LAT > 0)) begin
          cnt_d   = CNT_W'(MEM_LAT);
          state_d = MEMWAIT;
        end else begin
          exec_en = 1'b1;
          pc_d    = (BranchEn && Taken) ? BranchTarget : pc_q + PC_W'(1);
        end
      end
      MEMWAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          exec_en = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (Start) begin
          pc_d    = '0;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC     = pc_q;
  assign ExecEn = exec_en;
  assign Busy   = (state_q == RUN) || (state_q == MEMWAIT);
  assign Done   = (state_q == DONE);

`ifdef PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cyc_q, cyc_d, ins_q, ins_d;
  logic        start_run;

  assign start_run = ((state_q == IDLE) || (state_q == DONE)) && Start;

  always_comb begin
    cyc_d = cyc_q;
    ins_d = ins_q;
    if (start_run) begin
      cyc_d = '0;
      ins_d = '0;
    end else begin
      if (Busy)    cyc_d = sat_inc(cyc_q);
      if (exec_en) ins_d = sat_inc(ins_q);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign CycleCount = cyc_q;
  assign InstrCount = ins_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: one instance with MEM_LAT=2, one with MEM_LAT=0.
module tb_fetch_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Start0 = 1'b0;
  logic [8:0] Instruction = 9'h000;
  logic       BranchEn = 1'b0;
  logic       Taken = 1'b0;
  logic [9:0] BranchTarget = 10'h000;
  logic       MemAccess = 1'b0;

  logic [9:0] PC, PC0;
  logic       ExecEn, Busy, Done, ExecEn0, Busy0, Done0;
`ifdef PERF_CNT_EN
  logic [15:0] CycleCount, InstrCount, CycleCount0, InstrCount0;
`endif

  always #5 Clk = ~Clk;

  fetch_sequencer #(.PC_W(10), .MEM_LAT(2), .HALT_INSTR(9'h1FF)) u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .BranchEn(BranchEn), .Taken(Taken), .BranchTarget(BranchTarget),
    .MemAccess(MemAccess), .PC(PC), .ExecEn(ExecEn), .Busy(Busy), .Done(Done)
`ifdef PERF_CNT_EN
    , .CycleCount(CycleCount), .InstrCount(InstrCount)
`endif
  );

  fetch_sequencer #(.PC_W(10), .MEM_LAT(0), .HALT_INSTR(9'h1FF)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start0), .Instruction(Instruction),
    .BranchEn(BranchEn), .Taken(Taken), .BranchTarget(BranchTarget),
    .MemAccess(MemAccess), .PC(PC0), .ExecEn(ExecEn0), .Busy(Busy0), .Done(Done0)
`ifdef PERF_CNT_EN
    , .CycleCount(CycleCount0), .InstrCount(InstrCount0)
`endif
  );

  typedef struct {
    string       name;
    bit          sel;
    logic [9:0]  pc;
    logic        ee;
    logic        busy;
    logic        done;
    bit          chk_perf;
    logic [15:0] cyc;
    logic [15:0] ins;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bit          pend_perf = 0;
  logic [15:0] pend_cyc  = '0;
  logic [15:0] pend_ins  = '0;

  task automatic check(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h required=%h (t=%0t)", nm, fld, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge and queue the outputs expected in that cycle.
  task automatic step(input string nm, input bit sel, input logic rst, input logic st,
                      input logic [8:0] ins, input logic be, input logic tk,
                      input logic [9:0] tgt, input logic mem,
                      input logic [9:0] epc, input logic eee, input logic eb, input logic ed);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset        = rst;
    Start        = sel ? 1'b0 : st;
    Start0       = sel ? st : 1'b0;
    Instruction  = ins;
    BranchEn     = be;
    Taken        = tk;
    BranchTarget = tgt;
    MemAccess    = mem;
    e.name = nm; e.sel = sel; e.pc = epc; e.ee = eee; e.busy = eb; e.done = ed;
    e.chk_perf = pend_perf; e.cyc = pend_cyc; e.ins = pend_ins;
    pend_perf = 0;
    sb.push_back(e);
  endtask

  task automatic expect_perf(input logic [15:0] c, input logic [15:0] i);
    pend_perf = 1;
    pend_cyc  = c;
    pend_ins  = i;
  endtask

  always @(negedge Clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      if (!e.sel) begin
        check(e.name, "PC",     {6'd0, PC},       {6'd0, e.pc});
        check(e.name, "ExecEn", {15'd0, ExecEn},  {15'd0, e.ee});
        check(e.name, "Busy",   {15'd0, Busy},    {15'd0, e.busy});
        check(e.name, "Done",   {15'd0, Done},    {15'd0, e.done});
`ifdef PERF_CNT_EN
        if (e.chk_perf) begin
          check(e.name, "CycleCount", CycleCount, e.cyc);
          check(e.name, "InstrCount", InstrCount, e.ins);
        end
`endif
      end else begin
        check(e.name, "PC0",     {6'd0, PC0},      {6'd0, e.pc});
        check(e.name, "ExecEn0", {15'd0, ExecEn0}, {15'd0, e.ee});
        check(e.name, "Busy0",   {15'd0, Busy0},   {15'd0, e.busy});
        check(e.name, "Done0",   {15'd0, Done0},   {15'd0, e.done});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [8:0] NOP  = 9'h000;
  localparam logic [8:0] HALT = 9'h1FF;

  initial begin
    // Reset held, then idle with Start low
    step("rst_hold", 0, 0, 0, NOP, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0);
    step("rst_hold", 0, 0, 0, NOP, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step("idle", 0, 1, 0, NOP, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0);

    // Straight-line program ending in halt
    step("start",  0, 1, 1, NOP,  0, 0, 10'h000, 0, 10'h000, 0, 0, 0);
    step("run0",   0, 1, 0, NOP,  0, 0, 10'h000, 0, 10'h000, 1, 1, 0);
    step("run1",   0, 1, 0, NOP,  0, 0, 10'h000, 0, 10'h001, 1, 1, 0);
    step("run2",   0, 1, 0, NOP,  0, 0, 10'h000, 0, 10'h002, 1, 1, 0);
    step("halt3",  0, 1, 0, HALT, 0, 0, 10'h000, 0, 10'h003, 0, 1, 0);
    step("done3",  0, 1, 0, NOP,  0, 0, 10'h000, 0, 10'h003, 0, 0, 1);

    // Restart and walk to PC 4, then branch taken / not taken
    step("restart", 0, 1, 1, NOP, 0, 0, 10'h000, 0, 10'h003, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      step("walk", 0, 1, 0, NOP, 0, 0, 10'h000, 0, 10'(i), 1, 1, 0);
    step("br_taken",  0, 1, 0, NOP, 1, 1, 10'h020, 0, 10'h004, 1, 1, 0);
    step("br_back",   0, 1, 0, NOP, 1, 1, 10'h004, 0, 10'h020, 1, 1, 0);
    step("br_ntaken", 0, 1, 0, NOP, 1, 0, 10'h020, 0, 10'h004, 1, 1, 0);
    step("run5",      0, 1, 0, NOP, 0, 0, 10'h000, 0, 10'h005, 1, 1, 0);
    step("run6",      0, 1, 0, NOP, 0, 0, 10'h000, 0, 10'h006, 1, 1, 0);

    // Memory access with MEM_LAT=2; branch inputs must be ignored while waiting
    step("mem_issue", 0, 1, 0, NOP, 0, 0, 10'h000, 1, 10'h007, 0, 1, 0);
    step("mem_wait2", 0, 1, 0, NOP, 1, 1, 10'h100, 1, 10'h007, 0, 1, 0);
    step("mem_wait1", 0, 1, 0, NOP, 1, 1, 10'h100, 1, 10'h007, 1, 1, 0);
    step("br_top",    0, 1, 0, NOP, 1, 1, 10'h3FF, 0, 10'h008, 1, 1, 0);
    step("wrap",      0, 1, 0, NOP, 0, 0, 10'h000, 0, 10'h3FF, 1, 1, 0);
    step("after_wrap",0, 1, 0, NOP, 0, 0, 10'h000, 0, 10'h000, 1, 1, 0);

    // Halt beats branch and memory flags; restart from DONE
    step("halt_br",    0, 1, 0, HALT, 1, 1, 10'h055, 1, 10'h001, 0, 1, 0);
    step("done_hold",  0, 1, 0, NOP,  0, 0, 10'h000, 0, 10'h001, 0, 0, 1);
    step("done_start", 0, 1, 1, NOP,  0, 0, 10'h000, 0, 10'h001, 0, 0, 1);
    step("rerun0",     0, 1, 1, NOP,  0, 0, 10'h000, 0, 10'h000, 1, 1, 0);
    step("rehalt1",    0, 1, 0, HALT, 0, 0, 10'h000, 0, 10'h001, 0, 1, 0);

    // Two-instruction program: plain, memory, halt
    step("p_start", 0, 1, 1, NOP,  0, 0, 10'h000, 0, 10'h001, 0, 0, 1);
    step("p0",      0, 1, 0, NOP,  0, 0, 10'h000, 0, 10'h000, 1, 1, 0);
    step("p1_mem",  0, 1, 0, NOP,  0, 0, 10'h000, 1, 10'h001, 0, 1, 0);
    step("p1_w2",   0, 1, 0, NOP,  0, 0, 10'h000, 1, 10'h001, 0, 1, 0);
    step("p1_w1",   0, 1, 0, NOP,  0, 0, 10'h000, 1, 10'h001, 1, 1, 0);
    step("p2_halt", 0, 1, 0, HALT, 0, 0, 10'h000, 0, 10'h002, 0, 1, 0);
    expect_perf(16'd5, 16'd2);
    step("p_done",  0, 1, 0, NOP,  0, 0, 10'h000, 0, 10'h002, 0, 0, 1);
    expect_perf(16'd5, 16'd2);
    step("p_done2", 0, 1, 0, NOP,  0, 0, 10'h000, 0, 10'h002, 0, 0, 1);

    // Reset while the commit cycle of a memory wait is pending
    step("a_start", 0, 1, 1, NOP, 0, 0, 10'h000, 0, 10'h002, 0, 0, 1);
    step("a_mem",   0, 1, 0, NOP, 0, 0, 10'h000, 1, 10'h000, 0, 1, 0);
    step("a_w2",    0, 1, 0, NOP, 0, 0, 10'h000, 1, 10'h000, 0, 1, 0);
    expect_perf(16'd0, 16'd0);
    step("a_abort", 0, 0, 0, NOP, 0, 0, 10'h000, 1, 10'h000, 0, 0, 0);
    step("a_idle",  0, 1, 0, NOP, 0, 0, 10'h000, 0, 10'h000, 0, 0, 0);

    // MEM_LAT=0 instance: memory access is a single committing cycle
    step("z_start", 1, 1, 1, NOP,  0, 0, 10'h000, 0, 10'h000, 0, 0, 0);
    step("z0_br",   1, 1, 0, NOP,  1, 1, 10'h007, 0, 10'h000, 1, 1, 0);
    step("z7_mem",  1, 1, 0, NOP,  0, 0, 10'h000, 1, 10'h007, 1, 1, 0);
    step("z8",      1, 1, 0, NOP,  0, 0, 10'h000, 0, 10'h008, 1, 1, 0);
    step("z9_halt", 1, 1, 0, HALT, 0, 0, 10'h000, 0, 10'h009, 0, 1, 0);
    step("z_done",  1, 1, 0, NOP,  0, 0, 10'h000, 0, 10'h009, 0, 0, 1);

    repeat (3) @(negedge Clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch/sequencing unit for the 9-bit single-cycle core.
- Owns the program counter and the run state: start, run, stall on data-memory access, halt.
- Drives the instruction ROM address.
- Gates the control decoder's register-file and data-memory write enables through ExecEn.
- Consumes the decoder's branch enable, the ALU taken flag and the branch-target lookup output.

Parameters:
PC_W, 10, program counter width (instruction ROM depth 2^PC_W)
MEM_LAT, 2, extra stall cycles per data-memory access (0 = no stall)
HALT_INSTR, 9'h1FF, machine code that ends the program

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  level; begins a program run from PC 0
Instruction  input  9  current instruction from instruction ROM
BranchEn  input  1  decoder branch-instruction flag
Taken  input  1  ALU branch-condition flag
BranchTarget  input  PC_W  absolute target from branch lookup table
MemAccess  input  1  decoder flag: current instruction is a load or store
PC  output  PC_W  instruction ROM address
ExecEn  output  1  commit qualifier; decoder RegWrite/MemWrite are ANDed with it
Busy  output  1  high in RUN and MEMWAIT
Done  output  1  high in DONE

Behaviour:
- States: IDLE, RUN, MEMWAIT, DONE. Register updates happen on the Clk rising edge.
- Reset low (asynchronous):
  - state=IDLE, PC=0, wait counter=0.
  - ExecEn=0, Busy=0, Done=0 while held and after release.
- IDLE:
  - PC held at 0, ExecEn=0.
  - Start=1 -> RUN; PC stays 0, so the first fetched instruction is address 0.
- RUN, one instruction per cycle. Priority per cycle:
  1. Instruction==HALT_INSTR -> ExecEn=0, PC held, next state DONE. Halt has priority over BranchEn and MemAccess.
  2. MemAccess=1 and MEM_LAT>0 -> ExecEn=0, PC held, wait counter<=MEM_LAT, next state MEMWAIT.
  3. Otherwise ExecEn=1, and:
     - BranchEn&Taken=1: PC<=BranchTarget.
     - Otherwise: PC<=PC+1, modulo 2^PC_W (all-ones wraps to 0, no flag).
- MEMWAIT:
  - Counter decrements each cycle; PC held; Instruction is assumed stable.
  - Counter>1: ExecEn=0.
  - Counter==1: ExecEn=1 (the access commits), PC<=PC+1, next state RUN.
  - A memory instruction therefore occupies MEM_LAT+1 cycles with exactly one ExecEn pulse.
  - BranchEn is ignored in MEMWAIT.
- DONE:
  - Done=1, ExecEn=0, PC frozen at the halt address.
  - Start=1 -> RUN with PC<=0 (restart).
- Start is ignored in RUN and MEMWAIT.
- ExecEn, Busy and Done are combinational from state, counter and current inputs. PC is a register.
- Reset asserted mid-run or mid-MEMWAIT aborts immediately to the reset state. Any ExecEn pulse that had not yet occurred is lost.

Optional Feature:
PERF_CNT_EN.
- Defined:
  - Adds outputs CycleCount (16) and InstrCount (16).
  - Both clear to 0 on reset and on each IDLE/DONE->RUN transition.
  - CycleCount increments every cycle in RUN or MEMWAIT.
  - InstrCount increments on every ExecEn=1 cycle.
  - Both saturate at 16'hFFFF and hold their value in DONE.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset low, release, Start held 0 for 5 cycles -> PC=0, ExecEn=0, Busy=0, Done=0 throughout.
2. Start=1, three non-branch, non-memory instructions, then 9'h1FF -> PC 0,1,2,3 with ExecEn=1 on three cycles; at PC=3 ExecEn=0; next cycle Done=1, PC stays 3.
3. BranchEn=1 at PC=4 with BranchTarget=10'h020:
   - Taken=1 -> next PC=10'h020.
   - Repeat with Taken=0 -> next PC=5.
   - Both cases: ExecEn=1 on the branch cycle.
4. MemAccess=1 at PC=7, MEM_LAT=2 -> ExecEn 0,0,1 over three cycles, PC=7 for three cycles then 8. Repeat with MEM_LAT=0 -> single cycle, ExecEn=1, PC=8 next.
5. PC=10'h3FF with a non-branch instruction -> next PC=0. Halt with BranchEn=1, Taken=1 present -> DONE, no branch. Start=1 in DONE -> RUN with PC=0.
6. Reset driven low in the middle of MEMWAIT (counter=1 pending) -> immediately PC=0, state IDLE, ExecEn=0, no commit pulse. With PERF_CNT_EN, the 2-instruction program (PC0 plain, PC1 memory with MEM_LAT=2, PC2 halt) yields InstrCount=2 and CycleCount=5 in DONE.
